// File: rtl/pb_port_pkg.sv
// Shared constants for the pushbutton input port: register addresses and
// the default debounce window.
package pb_port_pkg;

   localparam int DB_CYCLES_DEFAULT = 500000;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, debounce counter and debounced level.
// rise is combinational so the edge register can capture on the same edge that level goes high.
module key_debounce
   import pb_port_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
   parameter int CW        = $clog2(DB_CYCLES + 1)
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic key_n,
   output logic level,
   output logic rise
);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] cnt;
   logic          at_limit;

   assign at_limit = (cnt == CW'(DB_CYCLES - 1));

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= ~key_n;
         sync_q2 <= sync_q1;
      end
   end

   // The counter only runs while the synchronized input disagrees with level.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync_q2 == level) begin
         cnt <= '0;
      end else if (at_limit) begin
         level <= sync_q2;
         cnt   <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign rise = sync_q2 & ~level & at_limit;

endmodule

// File: rtl/pb_edge_port.sv
// Memory-mapped pushbutton port: debounced levels, press-edge capture with
// write-1-to-clear, interrupt mask and a registered read port.
module pb_edge_port
   import pb_port_pkg::*;
#(
   parameter int N         = 4,
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
   parameter int CW        = $clog2(DB_CYCLES + 1)
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic [N-1:0] KEY,
   input  logic [1:0]   Addr,
   input  logic         Sel,
   input  logic         Rd,
   input  logic         Wr,
   input  logic [N-1:0] WrData,
   output logic [N-1:0] RdData,
   output logic         Irq
);

   logic [N-1:0] level;
   logic [N-1:0] rise;
   logic [N-1:0] mask;
   logic [N-1:0] edge_cap;
   logic [N-1:0] edge_clr;
   logic [N-1:0] rd_mux;
   logic         rd_en;
   logic         wr_en;

   for (genvar gi = 0; gi < N; gi++) begin : g_key
      key_debounce #(
         .DB_CYCLES (DB_CYCLES),
         .CW        (CW)
      ) u_db (
         .Clock  (Clock),
         .Resetn (Resetn),
         .key_n  (KEY[gi]),
         .level  (level[gi]),
         .rise   (rise[gi])
      );
   end

   assign rd_en    = Sel & Rd;
   assign wr_en    = Sel & Wr;
   assign edge_clr = (wr_en && (Addr == ADDR_EDGE)) ? WrData : '0;

   always_comb begin
      rd_mux = '0;
      case (Addr)
         ADDR_DATA: rd_mux = level;
         ADDR_MASK: rd_mux = mask;
         ADDR_EDGE: rd_mux = edge_cap;
         default:   rd_mux = '0;
      endcase
   end

   // A press arriving on the same edge as its clear wins, so no event is lost.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         mask     <= '0;
         edge_cap <= '0;
         RdData   <= '0;
         Irq      <= 1'b0;
      end else begin
         if (wr_en && (Addr == ADDR_MASK)) begin
            mask <= WrData;
         end
         edge_cap <= (edge_cap & ~edge_clr) | rise;
         if (rd_en) begin
            RdData <= rd_mux;
         end
         Irq <= |(edge_cap & mask);
      end
   end

endmodule

// File: tb/tb_pb_edge_port.sv
// Scoreboard bench for pb_edge_port: a window-based reference model predicts
// read data and Irq; a negedge monitor compares them against the DUT.
module tb_pb_edge_port;
   import pb_port_pkg::*;

   localparam int N  = 4;
   localparam int DB = 4;

   logic         Clock;
   logic         Resetn;
   logic [N-1:0] KEY;
   logic [1:0]   Addr;
   logic         Sel;
   logic         Rd;
   logic         Wr;
   logic [N-1:0] WrData;
   logic [N-1:0] RdData;
   logic         Irq;

   pb_edge_port #(
      .N         (N),
      .DB_CYCLES (DB)
   ) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .KEY    (KEY),
      .Addr   (Addr),
      .Sel    (Sel),
      .Rd     (Rd),
      .Wr     (Wr),
      .WrData (WrData),
      .RdData (RdData),
      .Irq    (Irq)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;
   bit started = 0;

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: ph[j] holds the pressed vector sampled j+1 edges ago.
   // A debounced bit flips once the DB most recent synchronized samples
   // (two edges of synchronizer delay) all disagree with it.
   logic [N-1:0] ph [0:DB];
   logic [N-1:0] m_d, m_mask, m_edge, m_nd, m_rise, m_clr;
   logic         m_irq;
   bit           all_diff;
   bit           rd_pend;
   logic [N-1:0] exp_q [$];

   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i <= DB; i++) ph[i] = '0;
         m_d = '0; m_mask = '0; m_edge = '0; m_irq = 1'b0;
         rd_pend = 0;
         exp_q.delete();
      end else begin
         rd_pend = Sel && Rd;
         if (rd_pend) begin
            case (Addr)
               2'd0:    exp_q.push_back(m_d);
               2'd2:    exp_q.push_back(m_mask);
               2'd3:    exp_q.push_back(m_edge);
               default: exp_q.push_back('0);
            endcase
         end
         m_irq = |(m_edge & m_mask);
         m_nd  = m_d;
         for (int b = 0; b < N; b++) begin
            all_diff = 1;
            for (int j = 1; j <= DB; j++)
               if (ph[j][b] == m_d[b]) all_diff = 0;
            if (all_diff) m_nd[b] = ~m_d[b];
         end
         m_rise = m_nd & ~m_d;
         m_clr  = (Sel && Wr && Addr == 2'd3) ? WrData : '0;
         m_edge = (m_edge & ~m_clr) | m_rise;
         if (Sel && Wr && Addr == 2'd2) m_mask = WrData;
         m_d = m_nd;
         for (int j = DB; j >= 1; j--) ph[j] = ph[j-1];
         ph[0] = ~KEY;
      end
   end

   logic [N-1:0] got_exp;
   always @(negedge Clock) begin
      if (started && Resetn) begin
         chk("irq", {3'b000, Irq}, {3'b000, m_irq});
         if (rd_pend) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got %h expected <none>", RdData);
            end else begin
               got_exp = exp_q.pop_front();
               chk("sb_rddata", RdData, got_exp);
            end
         end
      end
   end

   logic [N-1:0] kv = '1;

   task automatic bus(input bit sel, input bit rd, input bit wr,
                      input logic [1:0] a, input logic [N-1:0] wd);
      @(negedge Clock);
      KEY = kv; Sel = sel; Rd = rd; Wr = wr; Addr = a; WrData = wd;
   endtask

   task automatic idle(input int n);
      repeat (n) bus(0, 0, 0, 2'd0, '0);
   endtask

   task automatic rd_expect(input string nm, input logic [1:0] a, input logic [N-1:0] exp);
      bus(1, 1, 0, a, '0);
      @(negedge Clock);
      chk(nm, RdData, exp);
      Sel = 0; Rd = 0;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      #2 Resetn = 1'b0;
      #1;
      chk("rst_rddata", RdData, '0);
      chk("rst_irq", {3'b000, Irq}, 4'h0);
      Sel = 0; Rd = 0; Wr = 0;
      repeat (2) @(negedge Clock);
      #2 Resetn = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int hold [N];
   logic [N-1:0] k;

   initial begin
      Resetn = 1'b1; KEY = '1; Addr = '0; Sel = 0; Rd = 0; Wr = 0; WrData = '0;
      do_reset();
      started = 1;
      rd_expect("rst_data", 2'd0, 4'h0);
      rd_expect("rst_mask", 2'd2, 4'h0);
      rd_expect("rst_edge", 2'd3, 4'h0);

      // clean press and release
      kv = 4'b1110; idle(10);
      rd_expect("press_data", 2'd0, 4'b0001);
      rd_expect("press_edge", 2'd3, 4'b0001);
      kv = 4'b1111; idle(10);
      rd_expect("release_edge", 2'd3, 4'b0001);
      rd_expect("release_data", 2'd0, 4'b0000);

      // glitch rejection, then a real press
      bus(1, 0, 1, 2'd3, 4'hF);
      kv = 4'b1101; idle(3);
      kv = 4'b1111; idle(10);
      rd_expect("glitch_data", 2'd0, 4'b0000);
      rd_expect("glitch_edge", 2'd3, 4'b0000);
      kv = 4'b1101; idle(7);
      kv = 4'b1111; idle(10);
      rd_expect("long_edge", 2'd3, 4'b0010);

      // interrupt
      bus(1, 0, 1, 2'd3, 4'hF);
      bus(1, 0, 1, 2'd2, 4'b0100);
      kv = 4'b1011; idle(8);
      chk("irq_set", {3'b000, Irq}, 4'h1);
      kv = 4'b0011; idle(8);
      chk("irq_masked", {3'b000, Irq}, 4'h1);
      rd_expect("irq_edge", 2'd3, 4'b1100);
      bus(1, 0, 1, 2'd3, 4'b0100);
      @(negedge Clock);
      chk("irq_hold", {3'b000, Irq}, 4'h1);
      Sel = 0; Wr = 0;
      @(negedge Clock);
      chk("irq_clear", {3'b000, Irq}, 4'h0);
      rd_expect("irq_remain", 2'd3, 4'b1000);
      kv = 4'b1111; idle(10);

      // collision: clear lands on the edge where d[0] rises (6th edge after KEY)
      bus(1, 0, 1, 2'd3, 4'hF);
      idle(2);
      kv = 4'b1110; idle(5);
      bus(1, 0, 1, 2'd3, 4'b0001);
      rd_expect("collision", 2'd3, 4'b0001);
      kv = 4'b1111; idle(10);

      // bus rules
      rd_expect("rsvd", 2'd1, 4'h0);
      bus(1, 0, 1, 2'd0, 4'hF);
      rd_expect("data_ro", 2'd0, 4'h0);
      bus(1, 0, 1, 2'd2, 4'h3);
      bus(1, 1, 1, 2'd2, 4'hC);
      @(negedge Clock);
      chk("rdwr_old", RdData, 4'h3);
      Sel = 0; Rd = 0; Wr = 0;
      rd_expect("rdwr_new", 2'd2, 4'hC);
      bus(0, 1, 1, 2'd2, 4'h5);
      rd_expect("unsel", 2'd2, 4'hC);

      // reset in the middle of a press: a fresh press follows
      kv = 4'b0111; idle(3);
      do_reset();
      idle(10);
      rd_expect("fresh_edge", 2'd3, 4'b1000);
      rd_expect("fresh_data", 2'd0, 4'b1000);
      kv = 4'b1111; idle(10);

      // randomized traffic, checked by the scoreboard
      for (int b = 0; b < N; b++) hold[b] = 0;
      for (int c = 0; c < 3000; c++) begin
         k = kv;
         for (int b = 0; b < N; b++) begin
            if (hold[b] == 0) begin
               k[b]    = 1'($urandom_range(0, 1));
               hold[b] = $urandom_range(1, 12);
            end else begin
               hold[b]--;
            end
         end
         kv = k;
         if (c == 1500) do_reset();
         bus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), 4'($urandom));
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
